button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions the raw traffic-signal pedestrian push-button before it reaches the
//  MIX core's "button" input, which sets the overflow toggle. Pipeline:
//  synchronise -> debounce -> one press event per physical push -> re-arm lockout.
//  Emits a one-cycle press pulse and a sticky request level. The request is held
//  until software acknowledges it (JOV/JNOV overflow clear).
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles needed to accept a level change (>=1)
//  LOCKOUT_CYCLES   2500000 cycles after an accepted release during which input is ignored (>=0)
//  CNT_W            22      counter width; must hold max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES)
// PORTS
//  clk          in   1  system clock (the MIX clk)
//  reset        in   1  asynchronous, active-low reset
//  button_in    in   1  raw button, active-high, asynchronous to clk, bouncy
//  ack          in   1  one-cycle acknowledge; clears request
//  press        out  1  one-cycle pulse per accepted push; drives the MIX button input
//  request      out  1  sticky: set by press, cleared by ack
//  busy         out  1  high whenever state != IDLE
//  press_count  out  8  accepted presses, wraps 255->0 (debug)
// BEHAVIOUR
//  Reset (reset==0, async): sync flops=0, state=IDLE, cnt=0, press=0, request=0,
//   press_count=0; busy=0. Reset mid-debounce/lockout discards the event, with no press.
//  Sync: 2 flops; s = second flop. Only s is used downstream.
//  FSM (all transitions on posedge clk; cnt is CNT_W-bit):
//   IDLE:       s==1 -> DB_PRESS, cnt<=0.
//   DB_PRESS:   s==0 -> IDLE (glitch rejected). s==1 & cnt==DEBOUNCE_CYCLES-1 ->
//               PRESSED, press<=1 for exactly one cycle. Otherwise cnt<=cnt+1.
//   PRESSED:    s==0 -> DB_RELEASE, cnt<=0. A held button never re-fires press.
//   DB_RELEASE: s==1 -> PRESSED (no new press). s==0 & cnt==DEBOUNCE_CYCLES-1 ->
//               LOCKOUT, cnt<=0 (IDLE directly if LOCKOUT_CYCLES==0). Otherwise cnt++.
//   LOCKOUT:    s ignored; cnt==LOCKOUT_CYCLES-1 -> IDLE, else cnt++.
//  Latency: button_in first sampled high at edge 1 and held stable -> press high in
//   the cycle after edge DEBOUNCE_CYCLES+3.
//  press: registered; set on the PRESSED-entry edge, cleared on the next edge.
//  request: press sets it. ack clears it. If press and ack are both high in the
//   same cycle, set wins (request stays 1). ack while request==0 has no effect.
//  press_count: increments on the same edge that raises press; 8-bit wrap.
//  busy: combinational, state!=IDLE.
//  Unused or illegal state encodings -> IDLE on the next edge.
// TESTING (use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8)
//  Clean push held 20 cycles from edge 1 -> exactly one press, high after edge 7;
//   request=1; press_count=1.
//  Bounce: 1,0,1,0 alternate per cycle, then steady 1 -> no press during bounce; one
//   press 7 edges after steady 1 begins.
//  Glitch: button_in high for 3 cycles only -> no press; state returns to IDLE;
//   press_count=0.
//  Release and re-push within lockout (re-push 3 cycles after LOCKOUT entry, held
//   4 cycles) -> no second press. Re-push held after lockout -> second press;
//   press_count=2.
//  ack in the same cycle as press -> request stays 1. ack one cycle later ->
//   request=0 on the next edge.
//  Assert reset low mid-DB_PRESS (cnt=2) -> all outputs 0 immediately. Release
//   reset with the button held -> press only after a full new debounce (edge 7
//   relative to reset release).

Source files
------------

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce on press and release,
// one press pulse per physical push, re-arm lockout, sticky request with ack.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LOCKOUT_CYCLES  = 2500000,
  parameter int CNT_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_in,
  input  logic       ack,
  output logic       press,
  output logic       request,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    PRESSED    = 3'd2,
    DB_RELEASE = 3'd3,
    LOCKOUT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               NO_LOCK  = (LOCKOUT_CYCLES == 0);

  logic             sync_meta_reg;
  logic             sync_reg;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta_reg <= 1'b0;
      sync_reg      <= 1'b0;
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      press         <= 1'b0;
      request       <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      sync_meta_reg <= button_in;
      sync_reg      <= sync_meta_reg;
      press         <= 1'b0;

      // A press pulse outranks a simultaneous ack so no push is ever lost.
      if (press)
        request <= 1'b1;
      else if (ack)
        request <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (sync_reg) begin
            state_reg <= DB_PRESS;
            cnt_reg   <= '0;
          end
        end
        DB_PRESS: begin
          if (!sync_reg) begin
            state_reg <= IDLE;
          end else if (cnt_reg == DB_LAST) begin
            state_reg   <= PRESSED;
            press       <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync_reg) begin
            state_reg <= DB_RELEASE;
            cnt_reg   <= '0;
          end
        end
        DB_RELEASE: begin
          if (sync_reg) begin
            state_reg <= PRESSED;
          end else if (cnt_reg == DB_LAST) begin
            state_reg <= NO_LOCK ? IDLE : LOCKOUT;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        LOCKOUT: begin
          // Input is deliberately ignored here so contact chatter cannot re-arm early.
          if (cnt_reg == LO_LAST)
            state_reg <= IDLE;
          else
            cnt_reg <= cnt_reg + CNT_ONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random pushes, all checked
// against a timeline model built from run lengths of the synchronised button.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk;
  logic       reset;
  logic       button_in;
  logic       ack;
  logic       press;
  logic       request;
  logic       busy;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .button_in  (button_in),
    .ack        (ack),
    .press      (press),
    .request    (request),
    .busy       (busy),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phases of a push expressed as edge timestamps.
  localparam int ARMED = 0;
  localparam int HELD  = 1;
  localparam int LOCK  = 2;

  int         m_k;
  int         m_mode;
  int         m_start;
  int         m_lock_end;
  logic       m_b1, m_b2;
  logic       m_press, m_req, m_busy;
  logic [7:0] m_cnt;

  task automatic model_reset();
    m_k = 0; m_mode = ARMED; m_start = -1; m_lock_end = 0;
    m_b1 = 0; m_b2 = 0; m_press = 0; m_req = 0; m_busy = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic b, input logic a);
    logic s;
    logic ev;
    s = m_b2; m_b2 = m_b1; m_b1 = b;
    ev = 1'b0;
    if (m_mode == ARMED) begin
      // A push is accepted once s has stayed high for D edges after arming.
      if (s) begin
        if (m_start < 0) m_start = m_k;
        if (m_k - m_start == D) begin ev = 1'b1; m_mode = HELD; m_start = -1; end
      end else m_start = -1;
    end else if (m_mode == HELD) begin
      if (!s) begin
        if (m_start < 0) m_start = m_k;
        if (m_k - m_start == D) begin
          m_start = -1;
          if (L == 0) m_mode = ARMED;
          else begin m_mode = LOCK; m_lock_end = m_k + L; end
        end
      end else m_start = -1;
    end else begin
      if (m_k == m_lock_end) m_mode = ARMED;
    end
    m_req   = m_press | (m_req & ~a);
    m_press = ev;
    if (ev) m_cnt = m_cnt + 8'd1;
    m_busy = (m_mode != ARMED) || (m_start >= 0);
    m_k++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".press"},   {7'd0, press},   {7'd0, m_press});
    chk({tag, ".request"}, {7'd0, request}, {7'd0, m_req});
    chk({tag, ".busy"},    {7'd0, busy},    {7'd0, m_busy});
    chk({tag, ".count"},   press_count,     m_cnt);
  endtask

  task automatic step(input logic b, input logic a, input string tag);
    button_in = b;
    ack       = a;
    @(posedge clk);
    model_edge(b, a);
    #1;
    check_model(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".press"},   {7'd0, press},   8'd0);
    chk({tag, ".request"}, {7'd0, request}, 8'd0);
    chk({tag, ".busy"},    {7'd0, busy},    8'd0);
    chk({tag, ".count"},   press_count,     8'd0);
  endtask

  initial begin
    int first_press;
    int hold;
    logic lvl;

    reset = 1'b0; button_in = 1'b0; ack = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    reset = 1'b1;
    #2;

    // Clean push held 20 cycles: single press visible after edge 7.
    first_press = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b0, "clean");
      if (press && first_press < 0) first_press = i;
    end
    chk("clean_press_edge", 8'(first_press), 8'd7);
    chk("clean_request", {7'd0, request}, 8'd1);
    chk("clean_count", press_count, 8'd1);

    // Release; ack clears request one edge later.
    step(1'b0, 1'b1, "ack_clear");
    chk("ack_clear_request", {7'd0, request}, 8'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "release");

    // Re-push during lockout, held 4 cycles: ignored.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "lock_push");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, "lock_rel");
    chk("lock_count", press_count, 8'd1);

    // Push after lockout; ack raised exactly in the press cycle.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, press, "second");
      if (ack) begin
        chk("set_wins_request", {7'd0, request}, 8'd1);
        step(1'b1, 1'b1, "ack_late");
        chk("ack_late_request", {7'd0, request}, 8'd0);
      end
    end
    chk("second_count", press_count, 8'd2);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "idle");

    // Bounce 1,0,1,0 then steady: press 7 edges after steady high starts.
    step(1'b1, 1'b0, "bounce"); step(1'b0, 1'b0, "bounce");
    step(1'b1, 1'b0, "bounce"); step(1'b0, 1'b0, "bounce");
    first_press = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, "bounce_hold");
      if (press && first_press < 0) first_press = i;
    end
    chk("bounce_press_edge", 8'(first_press), 8'd7);
    chk("bounce_count", press_count, 8'd3);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "idle");

    // Glitch: three cycles high never becomes a press.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "glitch");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "glitch_rel");
    chk("glitch_count", press_count, 8'd3);
    chk("glitch_idle", {7'd0, busy}, 8'd0);

    // Reset mid-debounce, then release reset with button held.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "pre_reset");
    chk("pre_reset_busy", {7'd0, busy}, 8'd1);
    #1 reset = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    #1 reset = 1'b1;
    first_press = -1;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, "post_reset");
      if (press && first_press < 0) first_press = i;
    end
    chk("post_reset_press_edge", 8'(first_press), 8'd7);

    // Random pushes of varied hold times and sporadic acks.
    lvl = 1'b0;
    for (int r = 0; r < 60; r++) begin
      lvl  = ~lvl;
      hold = $urandom_range(1, 14);
      for (int i = 0; i < hold; i++)
        step(lvl, ($urandom_range(0, 9) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
